moving_average_filter_mc: RTL and testbench

Multi-channel, runtime-configurable moving-average filter with valid/ready streaming on both sides. It is the next-generation replacement for the single-channel fixed-window averager in the sample-conditioning path. Samples from up to NUM_CH interleaved channels arrive tagged with a channel index, and each channel keeps its own window state. Window length is a runtime power of two, up to 2^MAX_LOG2_WIN.

---
 rtl/moving_average_filter_mc.sv | 129 ++++++++++++
 tb/tb_moving_average_filter_mc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_filter_mc.sv
// Multi-channel moving-average filter with a runtime power-of-two window.
// Each channel keeps its own history ring, fill count and running sum. Results are registered with latency 1.
module moving_average_filter_mc #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH       = 4,
    parameter int MAX_LOG2_WIN = 4,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int WL_W = $clog2(MAX_LOG2_WIN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH_W-1:0]              in_ch,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic [WL_W-1:0]              win_log2,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_W-1:0]              out_ch,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_warm
);

    localparam int DEPTH = 1 << MAX_LOG2_WIN;
    localparam int PW    = MAX_LOG2_WIN;
    localparam int SW    = DATA_WIDTH + MAX_LOG2_WIN;

    logic signed [DATA_WIDTH-1:0] hist [NUM_CH][DEPTH];
    logic [PW-1:0]                wptr [NUM_CH];
    logic [PW:0]                  cnt  [NUM_CH];
    logic signed [SW-1:0]         sum  [NUM_CH];

    logic [WL_W-1:0]              win_q;
    logic [WL_W-1:0]              win_clamped;
    logic                         win_change;
    logic                         flush_all;
    logic                         accept;
    logic                         ch_ok;
    logic [CH_W-1:0]              ch_sel;
    logic [PW:0]                  win_size;

    logic [PW-1:0]                cur_wptr;
    logic [PW:0]                  cur_cnt;
    logic signed [SW-1:0]         cur_sum;
    logic [PW-1:0]                rd_idx;
    logic                         full;
    logic signed [DATA_WIDTH-1:0] old_raw;
    logic signed [SW-1:0]         old_ext;
    logic signed [SW-1:0]         in_ext;
    logic signed [SW-1:0]         sum_new;
    logic signed [DATA_WIDTH-1:0] avg;
    logic [PW:0]                  cnt_inc;
    logic [PW:0]                  cnt_next;
    logic                         warm_next;
    logic [PW-1:0]                wptr_next;

    // A window change is treated exactly like an external flush.
    always_comb begin
        win_clamped = (win_log2 > WL_W'(MAX_LOG2_WIN)) ? WL_W'(MAX_LOG2_WIN) : win_log2;
        win_change  = (win_clamped != win_q);
        flush_all   = flush || win_change;
        in_ready    = !rst && !flush_all && (!out_valid || out_ready);
        accept      = in_valid && in_ready;
        ch_ok       = (32'(in_ch) < 32'(NUM_CH));
        ch_sel      = ch_ok ? in_ch : '0;
        win_size    = (PW+1)'(1) << win_q;
    end

    // Channel state is read straight from the registers, so a same-channel
    // sample on the next cycle already sees the updated sum and pointer.
    always_comb begin
        cur_wptr  = wptr[ch_sel];
        cur_cnt   = cnt[ch_sel];
        cur_sum   = sum[ch_sel];
        rd_idx    = cur_wptr - win_size[PW-1:0];
        full      = (cur_cnt == win_size);
        old_raw   = hist[ch_sel][rd_idx];
        old_ext   = full ? {{MAX_LOG2_WIN{old_raw[DATA_WIDTH-1]}}, old_raw} : '0;
        in_ext    = {{MAX_LOG2_WIN{in_data[DATA_WIDTH-1]}}, in_data};
        sum_new   = cur_sum + in_ext - old_ext;
        avg       = DATA_WIDTH'(sum_new >>> win_q);
        cnt_inc   = cur_cnt + (PW+1)'(1);
        cnt_next  = full ? cur_cnt : cnt_inc;
        warm_next = (cnt_inc < win_size);
        wptr_next = cur_wptr + PW'(1);
    end

    // History is never cleared; the fill count decides which entries are live.
    always_ff @(posedge clk) begin
        if (accept && ch_ok) begin
            hist[ch_sel][cur_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q     <= win_clamped;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_warm  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
                cnt[c]  <= '0;
                sum[c]  <= '0;
            end
        end else if (flush_all) begin
            win_q     <= win_clamped;
            out_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
                cnt[c]  <= '0;
                sum[c]  <= '0;
            end
        end else if (accept && ch_ok) begin
            wptr[ch_sel] <= wptr_next;
            cnt[ch_sel]  <= cnt_next;
            sum[ch_sel]  <= sum_new;
            out_valid    <= 1'b1;
            out_ch       <= in_ch;
            out_data     <= avg;
            out_warm     <= warm_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_average_filter_mc.sv
// Bench for moving_average_filter_mc: directed scenarios plus randomized traffic
// checked against a queue-based model of the windowed average.
module tb_moving_average_filter_mc;

    localparam int DW    = 16;
    localparam int NCH   = 4;
    localparam int MAXL  = 4;
    localparam int CHW   = 2;
    localparam int WLW   = 3;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, in_valid, in_ready, flush, out_valid, out_ready, out_warm;
    logic [CHW-1:0]       in_ch, out_ch;
    logic signed [DW-1:0] in_data, out_data;
    logic [WLW-1:0]       win_log2;

    int errors = 0;
    int checks = 0;

    moving_average_filter_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_LOG2_WIN(MAXL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_data(in_data), .win_log2(win_log2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data), .out_warm(out_warm)
    );

    // Reference: per-channel queue of samples since the last flush
    int             m_winq = 0;
    int             hist_q[NCH][$];
    logic           m_ov = 1'b0;
    logic [CHW-1:0] m_och = '0;
    logic [DW-1:0]  m_odata = '0;
    logic           m_owarm = 1'b0;

    function automatic int clamp_win(int w);
        return (w > MAXL) ? MAXL : w;
    endfunction

    function automatic logic exp_in_ready();
        return !rst && !flush && (clamp_win(int'(win_log2)) == m_winq) && (!m_ov || out_ready);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) hist_q[c].delete();
    endtask

    task automatic model_accept(int ch, int d);
        longint s, q;
        int w, n, sz;
        hist_q[ch].push_back(d);
        if (hist_q[ch].size() > DEPTH) void'(hist_q[ch].pop_front());
        w  = 1 << m_winq;
        sz = hist_q[ch].size();
        n  = (sz < w) ? sz : w;
        s  = 0;
        for (int k = 0; k < n; k++) s += longint'(hist_q[ch][sz-1-k]);
        q = s / w;
        if ((s % w) != 0 && s < 0) q = q - 1;
        m_ov    = 1'b1;
        m_och   = CHW'(ch);
        m_odata = DW'(q);
        m_owarm = (sz < w);
    endtask

    // Advance the model by one clock using the inputs as they stand, then clock the DUT.
    task automatic tick();
        int   cw;
        logic acc;
        cw  = clamp_win(int'(win_log2));
        acc = in_valid && exp_in_ready();
        if (rst) begin
            model_clear();
            m_winq = cw; m_ov = 1'b0; m_och = '0; m_odata = '0; m_owarm = 1'b0;
        end else if (flush || cw != m_winq) begin
            m_winq = cw;
            model_clear();
            m_ov = 1'b0;
        end else if (acc && int'(in_ch) < NCH) begin
            model_accept(int'(in_ch), int'(in_data));
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(int ch, int d);
        in_valid = 1'b1; in_ch = CHW'(ch); in_data = DW'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'sd5;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
        checks++; if (out_warm !== 1'b0) begin errors++; $display("FAIL reset_out_warm: got %b want 0", out_warm); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_warmup();
        int wu_in[5]   = '{4, 8, 12, 16, 20};
        int wu_out[5]  = '{1, 3, 6, 10, 14};
        int wu_warm[5] = '{1, 1, 1, 0, 0};
        out_ready = 1'b1; win_log2 = 3'd2;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_ch = 2'd0; in_data = DW'(wu_in[i]);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL warmup_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL warmup_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_data !== DW'(wu_out[i])) begin errors++; $display("FAIL warmup_data[%0d]: got %0d want %0d", i, out_data, wu_out[i]); end
            checks++; if (out_warm !== 1'(wu_warm[i])) begin errors++; $display("FAIL warmup_warm[%0d]: got %b want %0d", i, out_warm, wu_warm[i]); end
            checks++; if (out_data !== m_odata) begin errors++; $display("FAIL warmup_model[%0d]: got %0d want %0d", i, out_data, $signed(m_odata)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL warmup_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_interleave();
        int il_ch[5]  = '{0, 1, 0, 1, 2};
        int il_in[5]  = '{10, -10, 30, -30, -5};
        int il_out[5] = '{5, -5, 20, -20, -3};
        win_log2 = 3'd1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL interleave_change_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 5; i++) begin
            send(il_ch[i], il_in[i]);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL interleave_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_data !== DW'(il_out[i])) begin errors++; $display("FAIL interleave_data[%0d]: got %0d want %0d", i, out_data, il_out[i]); end
            checks++; if (out_ch !== CHW'(il_ch[i])) begin errors++; $display("FAIL interleave_ch[%0d]: got %0d want %0d", i, out_ch, il_ch[i]); end
        end
    endtask

    task automatic test_backpressure();
        win_log2 = 3'd2;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = 2'd3; in_data = 16'sd8;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
        tick();
        in_data = 16'sd12;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_data !== 16'sd2) begin errors++; $display("FAIL bp_hold_data[%0d]: got %0d want 2", i, out_data); end
            checks++; if (out_ch !== 2'd3) begin errors++; $display("FAIL bp_hold_ch[%0d]: got %0d want 3", i, out_ch); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== 16'sd5) begin errors++; $display("FAIL bp_release_data: got %0d want 5", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got %b want 0", out_valid); end
    endtask

    task automatic test_window_change();
        win_log2 = 3'd3; out_ready = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            send(0, i);
            checks++; if (out_data !== m_odata) begin errors++; $display("FAIL wc_fill_model[%0d]: got %0d want %0d", i, out_data, $signed(m_odata)); end
        end
        checks++; if (out_data !== 16'sd4 || out_warm !== 1'b0) begin errors++; $display("FAIL wc_full: got %0d/%b want 4/0", out_data, out_warm); end
        out_ready = 1'b0; win_log2 = 3'd1; in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd99;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wc_change_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wc_pending_dropped: got %b want 0", out_valid); end
        in_valid = 1'b0; out_ready = 1'b1;
        send(0, 6);
        checks++; if (out_data !== 16'sd3 || out_warm !== 1'b1) begin errors++; $display("FAIL wc_after: got %0d/%b want 3/1", out_data, out_warm); end
    endtask

    task automatic test_flush_vs_input();
        win_log2 = 3'd2;
        tick();
        send(0, 40);
        checks++; if (out_data !== 16'sd10) begin errors++; $display("FAIL fvi_pre: got %0d want 10", out_data); end
        flush = 1'b1; in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd100;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fvi_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fvi_valid: got %b want 0", out_valid); end
        flush = 1'b0; in_valid = 1'b0;
        send(0, 100);
        checks++; if (out_data !== 16'sd25 || out_warm !== 1'b1) begin errors++; $display("FAIL fvi_after: got %0d/%b want 25/1", out_data, out_warm); end
    endtask

    task automatic test_extremes();
        win_log2 = 3'd4;
        tick();
        for (int i = 0; i < 40; i++) begin
            send(1, -32768);
            checks++; if (out_data !== m_odata || out_warm !== m_owarm) begin errors++; $display("FAIL ext_neg_model[%0d]: got %0d/%b want %0d/%b", i, out_data, out_warm, $signed(m_odata), m_owarm); end
            if (i >= 15) begin
                checks++; if (out_data !== -16'sd32768 || out_warm !== 1'b0) begin errors++; $display("FAIL ext_neg_full[%0d]: got %0d/%b want -32768/0", i, out_data, out_warm); end
            end
        end
        for (int i = 0; i < 40; i++) begin
            send(1, 32767);
            checks++; if (out_data !== m_odata) begin errors++; $display("FAIL ext_pos_model[%0d]: got %0d want %0d", i, out_data, $signed(m_odata)); end
            if (i >= 15) begin
                checks++; if (out_data !== 16'sd32767) begin errors++; $display("FAIL ext_pos_full[%0d]: got %0d want 32767", i, out_data); end
            end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; in_valid = 1'b1; in_ch = 2'd1; in_data = 16'sd50;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 16'sd0) begin errors++; $display("FAIL midrst_out: got %b/%0d want 0/0", out_valid, out_data); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        send(1, 16);
        checks++; if (out_data !== 16'sd1 || out_warm !== 1'b1) begin errors++; $display("FAIL midrst_after: got %0d/%b want 1/1", out_data, out_warm); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CHW'($urandom_range(0, NCH-1));
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) win_log2 = WLW'($urandom_range(0, 7));
            #1;
            checks++; if (in_ready !== exp_in_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_in_ready()); end
            tick();
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_ov); end
            if (m_ov) begin
                checks++;
                if (out_data !== m_odata || out_ch !== m_och || out_warm !== m_owarm) begin
                    errors++;
                    $display("FAIL rand_out[%0d]: got %0d/ch%0d/%b want %0d/ch%0d/%b", i, out_data, out_ch, out_warm, $signed(m_odata), m_och, m_owarm);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
        flush = 1'b0; out_ready = 1'b1; win_log2 = 3'd2;
        test_reset();
        test_warmup();
        test_interleave();
        test_backpressure();
        test_window_change();
        test_flush_vs_input();
        test_extremes();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
